// File: rtl/rl_lj_evaluation_nth_order.sv
// rl_lj_evaluation_nth_order
// Range-limited Lennard-Jones pair evaluator with ORDER-degree table
// interpolation. A pair enters a fixed-latency pipeline
// (r2 -> address -> ROM -> Horner -> force) and is written into a
// first-word-fall-through output FIFO. Input backpressure is purely
// credit based, so the pipeline never stalls.
// Compile-time macros:
//   RL_LJ_CUTOFF_DROP_EN : out-of-range pairs are dropped rather than emitted
//                          as zero force; their credit is returned instead.
// Coefficient ROM k holds LUT_DEFAULT[k] in every bin.
// The FP units are unfused, flush-to-zero, round-to-nearest-even models
// whose results are retimed through the stated IP latencies.
module rl_lj_evaluation_nth_order #(
    parameter int              ORDER       = 1,
    parameter int              SEGMENT_NUM = 14,
    parameter int              BIN_NUM     = 256,
    parameter int              EXP_MIN     = 127,
    parameter logic [31:0]     CUTOFF2     = 32'h43100000,
    parameter int              FIFO_DEPTH  = 32,
    parameter logic [3:0][31:0] LUT_DEFAULT = {32'h0, 32'h0, 32'h0, 32'h3F800000}
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         ivalid,
    output logic         oready,
    input  logic [127:0] reference,
    input  logic [127:0] neighbor,
    output logic         ovalid,
    input  logic         iready,
    output logic [127:0] forceoutput
);

    localparam int LAT       = 19 + 4 * ORDER;
    localparam int BIN_W     = $clog2(BIN_NUM);
    localparam int ROM_DEPTH = SEGMENT_NUM * BIN_NUM;
    localparam int ADDR_W    = $clog2(ROM_DEPTH);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    // Stage index at which each operation's result is first registered.
    localparam int ST_MULX   = 3;
    localparam int ST_FMAY   = 6;
    localparam int ST_FMAZ   = 10;
    localparam int ST_ADDR   = 14;
    localparam int ST_ROM    = 15;
    localparam int ST_HORNER = 17;
    localparam int ST_FORCE  = 17 + 4 * ORDER;

    typedef struct packed {
        logic                  vld;
        logic                  oor;
        logic [31:0]           tag;
        logic [31:0]           ax;    // d, later F, per axis
        logic [31:0]           ay;
        logic [31:0]           az;
        logic [31:0]           acc;   // running r2, then Horner accumulator
        logic [31:0]           r2;
        logic [ADDR_W-1:0]     addr;
        logic [ORDER:0][31:0]  coef;
    } stage_t;

    // ---------------- FP helpers ----------------
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        res;
        logic [47:0]        prod;
        logic [24:0]        man;
        logic signed [9:0]  e;
        logic               grd;
        logic               stk;
        logic               sgn;
        sgn  = a[31] ^ b[31];
        prod = 48'd0;
        man  = 25'd0;
        e    = 10'sd0;
        grd  = 1'b0;
        stk  = 1'b0;
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            res = {sgn, 31'd0};
        end else begin
            prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
            e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            if (prod[47]) begin
                man = {1'b0, prod[47:24]};
                grd = prod[23];
                stk = |prod[22:0];
                e   = e + 10'sd1;
            end else begin
                man = {1'b0, prod[46:23]};
                grd = prod[22];
                stk = |prod[21:0];
            end
            if (grd && (stk || man[0])) man = man + 25'd1;
            else                        man = man;
            if (man[24]) begin
                man = man >> 1;
                e   = e + 10'sd1;
            end else begin
                man = man;
            end
            if (e >= 10'sd255)     res = {sgn, 8'hFF, 23'd0};
            else if (e <= 10'sd0)  res = {sgn, 31'd0};
            else                   res = {sgn, e[7:0], man[22:0]};
        end
        fp_mul = res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0]        a;
        logic [31:0]        b;
        logic [31:0]        tmp;
        logic [31:0]        res;
        logic [7:0]         sh;
        logic [26:0]        ma;
        logic [26:0]        mb;
        logic [27:0]        sum;
        logic [24:0]        man;
        logic signed [9:0]  e;
        logic               grd;
        logic               stk;
        a   = (a_in[30:23] == 8'd0) ? 32'd0 : a_in;
        b   = (b_in[30:23] == 8'd0) ? 32'd0 : b_in;
        ma  = 27'd0;
        mb  = 27'd0;
        sum = 28'd0;
        man = 25'd0;
        e   = 10'sd0;
        grd = 1'b0;
        stk = 1'b0;
        sh  = 8'd0;
        // Keep the larger magnitude in a so the subtraction never goes negative.
        if (b[30:0] > a[30:0]) begin
            tmp = a;
            a   = b;
            b   = tmp;
        end else begin
            tmp = 32'd0;
        end
        if (b[30:23] == 8'd0) begin
            res = a;
        end else begin
            sh = a[30:23] - b[30:23];
            ma = {1'b1, a[22:0], 3'b000};
            mb = {1'b1, b[22:0], 3'b000};
            if (sh > 8'd26) begin
                mb = 27'd1;
            end else begin
                stk = |(mb & ((27'd1 << sh) - 27'd1));
                mb  = (mb >> sh) | {26'd0, stk};
            end
            e = $signed({2'b00, a[30:23]});
            if (a[31] == b[31]) sum = {1'b0, ma} + {1'b0, mb};
            else                sum = {1'b0, ma} - {1'b0, mb};
            if (sum == 28'd0) begin
                res = 32'd0;
            end else begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 10'sd1;
                end else begin
                    for (int i = 0; i < 27; i++) begin
                        if (!sum[26]) begin
                            sum = sum << 1;
                            e   = e - 10'sd1;
                        end else begin
                            sum = sum;
                        end
                    end
                end
                grd = sum[2];
                stk = |sum[1:0];
                man = {1'b0, sum[26:3]};
                if (grd && (stk || man[0])) man = man + 25'd1;
                else                        man = man;
                if (man[24]) begin
                    man = man >> 1;
                    e   = e + 10'sd1;
                end else begin
                    man = man;
                end
                if (e >= 10'sd255)     res = {a[31], 8'hFF, 23'd0};
                else if (e <= 10'sd0)  res = 32'd0;
                else                   res = {a[31], e[7:0], man[22:0]};
            end
        end
        fp_add = res;
    endfunction

    function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
        fp_sub = fp_add(a, {~b[31], b[30:0]});
    endfunction

    function automatic logic [31:0] fp_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        fp_fma = fp_add(fp_mul(a, b), c);
    endfunction

    // Table address from r2, clamped to the table range at both ends.
    function automatic logic [ADDR_W-1:0] lut_addr(input logic [31:0] r2);
        int a;
        int seg;
        seg = int'(r2[30:23]) - EXP_MIN;
        if (seg < 0)                 a = 0;
        else if (seg >= SEGMENT_NUM) a = ROM_DEPTH - 1;
        else                         a = seg * BIN_NUM + int'(r2[22 -: BIN_W]);
        lut_addr = ADDR_W'(a);
    endfunction

    // ---------------- pipeline ----------------
    stage_t               stage_q [1:LAT];
    stage_t               stage_d [1:LAT];
    logic [ORDER:0][31:0] rom_s;
    logic                 accept_s;

    assign accept_s = ivalid && oready;

    generate
        for (genvar k = 0; k <= ORDER; k++) begin : g_rom
            logic [31:0] lut_c [0:ROM_DEPTH-1];
            // Coefficient table contents.
            initial begin
                for (int i = 0; i < ROM_DEPTH; i++) lut_c[i] = LUT_DEFAULT[k];
            end
            assign rom_s[k] = lut_c[stage_q[ST_ADDR].addr];
        end
    endgenerate

    // Next value of every pipeline stage; most stages only retime their input.
    always_comb begin
        int j;
        j = 0;
        stage_d[1]     = '0;
        stage_d[1].vld = accept_s;
        stage_d[1].tag = neighbor[127:96];
        stage_d[1].ax  = fp_sub(neighbor[31:0],  reference[31:0]);
        stage_d[1].ay  = fp_sub(neighbor[63:32], reference[63:32]);
        stage_d[1].az  = fp_sub(neighbor[95:64], reference[95:64]);
        for (int k = 2; k <= LAT; k++) begin
            stage_d[k] = stage_q[k-1];
            if (k == ST_MULX) begin
                stage_d[k].acc = fp_mul(stage_q[k-1].ax, stage_q[k-1].ax);
            end else if (k == ST_FMAY) begin
                stage_d[k].acc = fp_fma(stage_q[k-1].ay, stage_q[k-1].ay, stage_q[k-1].acc);
            end else if (k == ST_FMAZ) begin
                stage_d[k].acc = fp_fma(stage_q[k-1].az, stage_q[k-1].az, stage_q[k-1].acc);
            end else if (k == ST_ADDR) begin
                // r2 is non-negative, so its bit pattern orders like an integer.
                stage_d[k].r2   = stage_q[k-1].acc;
                stage_d[k].oor  = (stage_q[k-1].acc >= CUTOFF2) ||
                                  (stage_q[k-1].acc[30:0] == 31'd0);
                stage_d[k].addr = lut_addr(stage_q[k-1].acc);
            end else if (k == ST_ROM) begin
                stage_d[k].coef = rom_s;
            end else if ((k >= ST_HORNER) && (k < ST_FORCE) && (((k - ST_HORNER) % 4) == 0)) begin
                j = (k - ST_HORNER) / 4;
                if (j == 0) begin
                    stage_d[k].acc = fp_fma(stage_q[k-1].coef[ORDER], stage_q[k-1].r2,
                                            stage_q[k-1].coef[ORDER-1]);
                end else begin
                    stage_d[k].acc = fp_fma(stage_q[k-1].acc, stage_q[k-1].r2,
                                            stage_q[k-1].coef[ORDER-1-j]);
                end
            end else if (k == ST_FORCE) begin
                stage_d[k].ax = fp_mul(stage_q[k-1].acc, stage_q[k-1].ax);
                stage_d[k].ay = fp_mul(stage_q[k-1].acc, stage_q[k-1].ay);
                stage_d[k].az = fp_mul(stage_q[k-1].acc, stage_q[k-1].az);
            end else begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Pipeline stage registers; reset discards everything in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= LAT; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 1; k <= LAT; k++) stage_q[k] <= stage_d[k];
        end
    end

    // ---------------- output FIFO and credits ----------------
    logic [127:0]     mem_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, credit_q, credit_d;
    logic             ovalid_q, ovalid_d, oready_q, oready_d;
    logic [127:0]     head_q, head_d;
    logic             fifo_wr_s, fifo_rd_s, drop_s;
    logic [127:0]     wr_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // FIFO write/drop decision, pointer, count, credit and next-head logic.
    always_comb begin
        wr_data_s = stage_q[LAT].oor ? {stage_q[LAT].tag, 96'd0}
                                     : {stage_q[LAT].tag, stage_q[LAT].az,
                                        stage_q[LAT].ay, stage_q[LAT].ax};
`ifdef RL_LJ_CUTOFF_DROP_EN
        fifo_wr_s = stage_q[LAT].vld && !stage_q[LAT].oor;
        drop_s    = stage_q[LAT].vld &&  stage_q[LAT].oor;
`else
        fifo_wr_s = stage_q[LAT].vld;
        drop_s    = 1'b0;
`endif
        fifo_rd_s = ovalid_q && iready;
        wr_ptr_d  = fifo_wr_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = fifo_rd_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CNT_W'(fifo_wr_s) - CNT_W'(fifo_rd_s);
        credit_d  = credit_q + CNT_W'(fifo_rd_s) + CNT_W'(drop_s) - CNT_W'(accept_s);
        ovalid_d  = (count_d != {CNT_W{1'b0}});
        oready_d  = (credit_d != {CNT_W{1'b0}});
        if (count_d == {CNT_W{1'b0}})
            head_d = 128'd0;
        else if (fifo_wr_s && (wr_ptr_q == rd_ptr_d))
            head_d = wr_data_s;
        else
            head_d = mem_q[rd_ptr_d];
    end

    // FIFO storage; contents are only visible through the masked head register.
    always_ff @(posedge clock) begin
        if (fifo_wr_s) mem_q[wr_ptr_q] <= wr_data_s;
        else           mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end

    // FIFO control, credit counter and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            credit_q <= CNT_W'(FIFO_DEPTH);
            ovalid_q <= 1'b0;
            oready_q <= 1'b0;
            head_q   <= 128'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            ovalid_q <= ovalid_d;
            oready_q <= oready_d;
            head_q   <= head_d;
        end
    end

    assign ovalid      = ovalid_q;
    assign oready      = oready_q;
    assign forceoutput = head_q;

endmodule

// File: tb/tb_rl_lj_evaluation_nth_order.sv
// Scoreboard bench for rl_lj_evaluation_nth_order (ORDER=1, default tables
// c0 = 1.0, c1 = 0, so f = 1.0 and in-range F equals d).
module tb_rl_lj_evaluation_nth_order;

    localparam int LAT1 = 19 + 4 * 1 + 1;   // cycles from accept cycle to ovalid
`ifdef RL_LJ_CUTOFF_DROP_EN
    localparam int DROP = 1;
`else
    localparam int DROP = 0;
`endif

    logic         clock = 1'b0;
    logic         resetn = 1'b1;
    logic         ivalid = 1'b0;
    logic         iready = 1'b1;
    logic [127:0] reference = 128'd0;
    logic [127:0] neighbor = 128'd0;
    logic         oready;
    logic         ovalid;
    logic [127:0] forceoutput;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [127:0] exp_q[$];
    int           pop_cyc[$];

    rl_lj_evaluation_nth_order dut (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
        .reference(reference), .neighbor(neighbor), .ovalid(ovalid),
        .iready(iready), .forceoutput(forceoutput)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Small-integer to FP32 encoder used to build stimulus and expectations.
    function automatic logic [31:0] i2f(input int v);
        int          mag;
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if ((mag >> i) != 0) p = i;
        m = 32'(mag) << (23 - p);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Drive one pair on the inputs and push its expected result.
    task automatic load_pair(input int rx, ry, rz, nx, ny, nz, input int tag);
        int dx, dy, dz, r2;
        bit oor;
        dx = nx - rx; dy = ny - ry; dz = nz - rz;
        r2 = dx * dx + dy * dy + dz * dz;
        oor = (r2 >= 144) || (r2 == 0);
        reference = {32'd0, i2f(rz), i2f(ry), i2f(rx)};
        neighbor  = {32'(tag), i2f(nz), i2f(ny), i2f(nx)};
        ivalid = 1'b1;
        if (!oor)
            exp_q.push_back({32'(tag), i2f(dz), i2f(dy), i2f(dx)});
        else if (DROP == 0)
            exp_q.push_back({32'(tag), 96'd0});
    endtask

    // Present a pair at a negedge and return right after the edge that accepts it.
    task automatic send(input int rx, ry, rz, nx, ny, nz, input int tag);
        int w;
        w = 0;
        @(negedge clock);
        while (!oready && w < 200) begin
            @(negedge clock);
            w++;
        end
        check_eq("send_ready", {127'd0, oready}, 128'd1);
        load_pair(rx, ry, rz, nx, ny, nz, tag);
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        ivalid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Latency counted with the accept cycle as cycle 0.
    task automatic measure(output int n);
        n = 1;
        @(negedge clock);
        ivalid = 1'b0;
        while (n < 100) begin
            @(posedge clock);
            n++;
            #1;
            if (ovalid) break;
        end
    endtask

    // Output side of the scoreboard: every transfer out pops and compares.
    always @(negedge clock) begin
        if (resetn && ovalid && iready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_unexpected", {127'd0, ovalid}, 128'd0);
            end else begin
                check_eq("out_data", forceoutput, exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int n, base, sent, seen;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_ovalid", {127'd0, ovalid}, 128'd0);
        check_eq("rst_force", forceoutput, 128'd0);
        check_eq("rst_oready", {127'd0, oready}, 128'd0);
        resetn = 1'b1;
        @(negedge clock);
        check_eq("rel_oready", {127'd0, oready}, 128'd1);

        // Single pair latency and data.
        send(1, 1, 1, 2, 3, 5, 7);
        measure(n);
        check_eq("latency", 128'(n), 128'(LAT1));
        idle(5);

        // Back-to-back pairs come out on consecutive cycles.
        base = pop_cyc.size();
        send(0, 0, 0, 2, 2, 2, 21);
        send(1, 1, 1, 2, 5, 9, 22);
        idle(LAT1 + 5);
        check_eq("b2b_count", 128'(pop_cyc.size() - base), 128'd2);
        if (pop_cyc.size() >= base + 2)
            check_eq("b2b_gap", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd1);

        // r2 exactly at the cutoff, then a same-position pair.
        base = pop_cyc.size();
        send(0, 0, 0, 12, 0, 0, 33);
        idle(LAT1 + 5);
        check_eq("cutoff_outs", 128'(pop_cyc.size() - base), 128'(1 - DROP));
        base = pop_cyc.size();
        send(3, 3, 3, 3, 3, 3, 34);
        idle(LAT1 + 5);
        check_eq("zero_r2_outs", 128'(pop_cyc.size() - base), 128'(1 - DROP));

        // Credit exhaustion with the consumer stalled.
        iready = 1'b0;
        sent = 0;
        for (int i = 0; i < 60 && sent < 40; i++) begin
            @(negedge clock);
            if (oready) begin
                load_pair(0, 0, 0, 1, 2, (sent % 7) + 1, 100 + sent);
                sent++;
            end else begin
                ivalid = 1'b0;
            end
        end
        @(negedge clock);
        ivalid = 1'b0;
        check_eq("credit_accepts", 128'(sent), 128'd32);
        repeat (LAT1 + 5) @(negedge clock);
        check_eq("full_oready", {127'd0, oready}, 128'd0);
        check_eq("full_ovalid", {127'd0, ovalid}, 128'd1);
        base = pop_cyc.size();
        iready = 1'b1;
        repeat (40) @(negedge clock);
        check_eq("drain_count", 128'(pop_cyc.size() - base), 128'd32);
        check_eq("drain_oready", {127'd0, oready}, 128'd1);
        for (int i = 32; i < 40; i++) send(0, 0, 0, 1, 2, (i % 7) + 1, 100 + i);
        idle(LAT1 + 5);
        check_eq("stream_left", 128'(exp_q.size()), 128'd0);

        // Reset with pairs in flight.
        for (int i = 0; i < 10; i++) send(0, 0, 0, 1, 1, i + 1, 200 + i);
        idle(5);
        resetn = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        check_eq("mid_rst_ovalid", {127'd0, ovalid}, 128'd0);
        check_eq("mid_rst_oready", {127'd0, oready}, 128'd0);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (ovalid) seen++;
        end
        check_eq("post_rst_quiet", 128'(seen), 128'd0);
        send(2, 1, 0, 5, 5, 5, 300);
        measure(n);
        check_eq("post_rst_latency", 128'(n), 128'(LAT1));
        idle(5);
        check_eq("final_queue", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
